// File: rtl/tlv5618_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlv5618_pkg
//  Description : Shared constants, command codes and FSM state type for the
//                TLV5618 serial-port receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlv5618_pkg;

  localparam int WORD_W = 16;
  localparam int DATA_W = 12;

  // Control-bit positions inside the 16-bit serial word
  localparam int BIT_R1  = 15;
  localparam int BIT_SPD = 14;
  localparam int BIT_PWR = 13;
  localparam int BIT_R0  = 12;

  // Register-select codes carried in {R1,R0}
  localparam logic [1:0] CMD_B_BUF = 2'b00;
  localparam logic [1:0] CMD_BUF   = 2'b01;
  localparam logic [1:0] CMD_A_UPD = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The select bits are not adjacent in the word, so gather them here
  function automatic logic [1:0] r1r0_of(input logic [WORD_W-1:0] w);
    return {w[BIT_R1], w[BIT_R0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlv5618_spi_rx_sig_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tlv5618_spi_rx_sig_sync
//  Description : Multi-flop synchronizer for one asynchronous serial line plus
//                an extra delay flop for edge detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlv5618_spi_rx_sig_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LVL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  // Shift the pin through the synchronizer chain; reset to the idle level so
  // leaving reset never looks like an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{IDLE_LVL}};
      r_dly  <= IDLE_LVL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_dly;

endmodule
`default_nettype wire

// File: rtl/tlv5618_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tlv5618_spi_rx
//  Description : Responder-side model of the TLV5618 3-wire serial port.
//                Oversamples cs_n/sclk/din, assembles 16-bit words and
//                applies them to the DAC A / DAC B / BUFFER / SPD / PWR map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlv5618_spi_rx
  import tlv5618_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_CODE  = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DAC_cs_n,
  input  logic              DAC_sclk,
  input  logic              DAC_din,
  output logic [WORD_W-1:0] word,
  output logic              word_vld,
  output logic [DATA_W-1:0] dac_a,
  output logic [DATA_W-1:0] dac_b,
  output logic [DATA_W-1:0] buffer,
  output logic              spd,
  output logic              pwr_dn,
  output logic              frame_err,
  output logic              cmd_err,
  output logic              busy
);

  localparam logic [4:0] c_FULL_CNT = 5'd16;
  localparam logic [4:0] c_SAT_CNT  = 5'd17;

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_din_lvl, w_din_rise, w_din_fall;

  state_t            r_state;
  logic [WORD_W-1:0] r_sr;
  logic [4:0]        r_bit_cnt;
  logic [WORD_W-1:0] r_word;
  logic              r_word_vld;
  logic [DATA_W-1:0] r_dac_a;
  logic [DATA_W-1:0] r_dac_b;
  logic [DATA_W-1:0] r_buffer;
  logic              r_spd;
  logic              r_pwr_dn;
  logic              r_frame_err;
  logic              r_cmd_err;

  tlv5618_spi_rx_sig_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_sig(DAC_cs_n),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  tlv5618_spi_rx_sig_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_sig(DAC_sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  tlv5618_spi_rx_sig_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_din (
    .clk(clk), .rst(rst), .i_sig(DAC_din),
    .o_level(w_din_lvl), .o_rise(w_din_rise), .o_fall(w_din_fall)
  );

  // Only edges of cs_n, the falling edge of sclk and the level of din matter
  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, w_cs_lvl, w_sclk_lvl, w_sclk_rise, w_din_rise, w_din_fall};

  // Frame FSM: collect bits while cs_n is low, decode and commit on its rise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_word      <= '0;
      r_word_vld  <= 1'b0;
      r_dac_a     <= RESET_CODE;
      r_dac_b     <= RESET_CODE;
      r_buffer    <= RESET_CODE;
      r_spd       <= 1'b0;
      r_pwr_dn    <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_word_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state   <= SHIFT;
            r_sr      <= '0;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // cs_n rise has priority: a coincident sclk fall is not shifted in
          if (w_cs_rise) begin
            r_state <= IDLE;
            if (r_bit_cnt != c_FULL_CNT) begin
              r_frame_err <= 1'b1;
            end else begin
              r_word <= r_sr;
              case (r1r0_of(r_sr))
                CMD_B_BUF: begin
                  r_dac_b  <= r_sr[DATA_W-1:0];
                  r_buffer <= r_sr[DATA_W-1:0];
                end
                CMD_BUF: begin
                  r_buffer <= r_sr[DATA_W-1:0];
                end
                CMD_A_UPD: begin
                  r_dac_a <= r_sr[DATA_W-1:0];
                  r_dac_b <= r_buffer;
                end
                default: begin
                  r_cmd_err <= 1'b1;
                end
              endcase
              if (r1r0_of(r_sr) != CMD_RSVD) begin
                r_spd      <= r_sr[BIT_SPD];
                r_pwr_dn   <= r_sr[BIT_PWR];
                r_word_vld <= 1'b1;
              end
            end
          end else if (w_sclk_fall) begin
            r_sr <= {r_sr[WORD_W-2:0], w_din_lvl};
            if (r_bit_cnt != c_SAT_CNT) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign word      = r_word;
  assign word_vld  = r_word_vld;
  assign dac_a     = r_dac_a;
  assign dac_b     = r_dac_b;
  assign buffer    = r_buffer;
  assign spd       = r_spd;
  assign pwr_dn    = r_pwr_dn;
  assign frame_err = r_frame_err;
  assign cmd_err   = r_cmd_err;
  assign busy      = (r_state == SHIFT);

endmodule
`default_nettype wire
